// File: rtl/arp_tbl_access_arbiter_if.sv
// ---------------------------------------------------------------------------------------------
// arp_tbl_access_arbiter_if
//   Bundles the two requester ports (host register path h_*, ARP engine e_*) and the single
//   ARP-table access port (tbl_*) that arp_tbl_access_arbiter multiplexes.
//
//   Signals
//     h_req/e_req      request, held high until ack
//     h_wr/e_wr        1 = write, 0 = read, stable while req
//     h_addr/e_addr    entry address, stable while req
//     h_wdata/e_wdata  write data, stable while req
//     h_rdata/e_rdata  read data, valid with ack (0 otherwise)
//     h_ack/e_ack      one-cycle completion pulse
//     h_err/e_err      with ack: 1 = table ack timeout
//     tbl_rd_req       one-cycle read pulse to the table
//     tbl_wr_req       one-cycle write pulse to the table
//     tbl_rd_addr      read address
//     tbl_wr_addr      write address
//     tbl_wr_data      write data
//     tbl_rd_data      table read data
//     tbl_rd_ack       table read ack
//     tbl_wr_ack       table write ack
//
//   Modports
//     slave   the arbiter's view
//     master  the requesters' and the table's view
// ---------------------------------------------------------------------------------------------
interface arp_tbl_access_arbiter_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_ADDR_WIDTH       = 5
);
    localparam int unsigned C_ENTRY_WIDTH = 3 * C_S_AXI_DATA_WIDTH;

    logic                     h_req;
    logic                     h_wr;
    logic [C_ADDR_WIDTH-1:0]  h_addr;
    logic [C_ENTRY_WIDTH-1:0] h_wdata;
    logic [C_ENTRY_WIDTH-1:0] h_rdata;
    logic                     h_ack;
    logic                     h_err;

    logic                     e_req;
    logic                     e_wr;
    logic [C_ADDR_WIDTH-1:0]  e_addr;
    logic [C_ENTRY_WIDTH-1:0] e_wdata;
    logic [C_ENTRY_WIDTH-1:0] e_rdata;
    logic                     e_ack;
    logic                     e_err;

    logic                     tbl_rd_req;
    logic                     tbl_wr_req;
    logic [C_ADDR_WIDTH-1:0]  tbl_rd_addr;
    logic [C_ADDR_WIDTH-1:0]  tbl_wr_addr;
    logic [C_ENTRY_WIDTH-1:0] tbl_wr_data;
    logic [C_ENTRY_WIDTH-1:0] tbl_rd_data;
    logic                     tbl_rd_ack;
    logic                     tbl_wr_ack;

    modport slave (
        input  h_req, h_wr, h_addr, h_wdata,
        output h_rdata, h_ack, h_err,
        input  e_req, e_wr, e_addr, e_wdata,
        output e_rdata, e_ack, e_err,
        output tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
        input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack
    );

    modport master (
        output h_req, h_wr, h_addr, h_wdata,
        input  h_rdata, h_ack, h_err,
        output e_req, e_wr, e_addr, e_wdata,
        input  e_rdata, e_ack, e_err,
        input  tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
        output tbl_rd_data, tbl_rd_ack, tbl_wr_ack
    );
endinterface

// File: rtl/arp_tbl_access_arbiter.sv
// ---------------------------------------------------------------------------------------------
// arp_tbl_access_arbiter
//   Shares the single ARP-table access port between the host register path (h_*) and the
//   hardware ARP engine (e_*). Round-robin grant on ties, one transaction in flight, and a
//   table-ack timeout that completes the transaction with err = 1 and rdata = 0.
//
//   Ports
//     AXI_ACLK     clock
//     AXI_RESETN   asynchronous active-low reset
//     bus          requester and table signals (arp_tbl_access_arbiter_if.slave); the interface
//                  instance must use the same C_S_AXI_DATA_WIDTH / C_ADDR_WIDTH as this module
//     busy         1 whenever a transaction is in flight (state != IDLE)
//     timeout_cnt  saturating count of timed-out transactions
//
//   Flow: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. A request sampled at edge N drives the table
//   request in cycle N+1, a table ack in cycle N+2 gives the requester ack in cycle N+3.
// ---------------------------------------------------------------------------------------------
module arp_tbl_access_arbiter #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_ADDR_WIDTH       = 5,
    parameter int unsigned C_ACK_TIMEOUT      = 16
) (
    input  logic                     AXI_ACLK,
    input  logic                     AXI_RESETN,
    arp_tbl_access_arbiter_if.slave  bus,
    output logic                     busy,
    output logic [31:0]              timeout_cnt
);
    localparam int unsigned C_ENTRY_WIDTH = 3 * C_S_AXI_DATA_WIDTH;
    localparam int unsigned C_CNT_WIDTH   = (C_ACK_TIMEOUT > 2) ? $clog2(C_ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t                   state_q, state_d;
    logic                     grant_e_q, grant_e_d;   // current/last grant: 1 = engine
    logic                     wr_q, wr_d;
    logic [C_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [C_ENTRY_WIDTH-1:0] wdata_q, wdata_d;
    logic [C_ENTRY_WIDTH-1:0] rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [C_CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]              timeout_cnt_q, timeout_cnt_d;
    logic                     pick_e;
    logic                     ack_match;
    logic                     done;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q       <= StIdle;
            grant_e_q     <= 1'b1;   // so the host wins the first tie
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            wait_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_e_q     <= grant_e_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Only the ack type that matches the issued command completes the transaction.
    assign ack_match = wr_q ? bus.tbl_wr_ack : bus.tbl_rd_ack;

    always_comb begin
        state_d       = state_q;
        grant_e_d     = grant_e_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        pick_e        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.h_req || bus.e_req) begin
                    // On a tie the requester that was not served last goes next.
                    pick_e    = (bus.h_req && bus.e_req) ? ~grant_e_q : bus.e_req;
                    grant_e_d = pick_e;
                    wr_d      = pick_e ? bus.e_wr    : bus.h_wr;
                    addr_d    = pick_e ? bus.e_addr  : bus.h_addr;
                    wdata_d   = pick_e ? bus.e_wdata : bus.h_wdata;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (ack_match) begin
                    rdata_d = wr_q ? '0 : bus.tbl_rd_data;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (wait_cnt_q == C_CNT_WIDTH'(C_ACK_TIMEOUT - 1)) begin
                    // This was the last allowed WAIT cycle.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                    if (timeout_cnt_q != 32'hFFFF_FFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 32'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign done = (state_q == StDone);

    assign bus.tbl_rd_req  = (state_q == StIssue) && !wr_q;
    assign bus.tbl_wr_req  = (state_q == StIssue) && wr_q;
    assign bus.tbl_rd_addr = addr_q;
    assign bus.tbl_wr_addr = addr_q;
    assign bus.tbl_wr_data = wdata_q;

    assign bus.h_ack   = done && !grant_e_q;
    assign bus.h_err   = done && !grant_e_q && err_q;
    assign bus.h_rdata = (done && !grant_e_q) ? rdata_q : '0;

    assign bus.e_ack   = done && grant_e_q;
    assign bus.e_err   = done && grant_e_q && err_q;
    assign bus.e_rdata = (done && grant_e_q) ? rdata_q : '0;

    assign busy        = (state_q != StIdle);
    assign timeout_cnt = timeout_cnt_q;
endmodule

// File: tb/tb_arp_tbl_access_arbiter.sv
// Bench for arp_tbl_access_arbiter: a transaction-level reference model checked every cycle,
// a table responder with programmable ack behaviour, and directed scenarios with literal checks.
module tb_arp_tbl_access_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 16;
    localparam int EW = 3 * DW;
    localparam logic [EW-1:0] T1_DATA = 96'h0000_AABBCCDDEEFF_0A000001;
    localparam logic [EW-1:0] T2_DATA = 96'h1234_5678_9ABC_DEF0_0BAD_F00D;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_RESETN = 1'b0;
    logic        busy;
    logic [31:0] timeout_cnt;

    arp_tbl_access_arbiter_if #(.C_S_AXI_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) bus ();

    arp_tbl_access_arbiter #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_ADDR_WIDTH      (AW),
        .C_ACK_TIMEOUT     (TO)
    ) dut (
        .AXI_ACLK   (AXI_ACLK),
        .AXI_RESETN (AXI_RESETN),
        .bus        (bus),
        .busy       (busy),
        .timeout_cnt(timeout_cnt)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    int cyc = 0;
    always @(posedge AXI_ACLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] init_val(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'hDEAD_BEEF ^ 32'(i), 32'h0000_1000 + 32'(i)};
    endfunction

    // Table contents as seen by the responder, and the model's independent copy.
    logic [EW-1:0] tbl_mem [32];
    logic [EW-1:0] m_mem   [32];

    // Responder: acks arrive dly cycles after the table request (0 = never).
    int rd_delay = 1;
    int wr_delay = 1;
    int stray_at = 0;

    initial begin
        bit            is_wr;
        int            dly;
        int            last_k;
        logic [AW-1:0] a;
        logic [EW-1:0] d;
        bus.tbl_rd_ack  = 1'b0;
        bus.tbl_wr_ack  = 1'b0;
        bus.tbl_rd_data = '0;
        forever begin
            @(negedge AXI_ACLK);
            if (AXI_RESETN && (bus.tbl_rd_req || bus.tbl_wr_req)) begin
                is_wr  = bus.tbl_wr_req;
                a      = is_wr ? bus.tbl_wr_addr : bus.tbl_rd_addr;
                d      = bus.tbl_wr_data;
                dly    = is_wr ? wr_delay : rd_delay;
                last_k = (dly == 0) ? TO + 2 : dly + 1;
                if (stray_at >= last_k) last_k = stray_at + 1;
                for (int k = 1; k <= last_k; k++) begin
                    @(posedge AXI_ACLK);
                    #1;
                    bus.tbl_rd_ack  = 1'b0;
                    bus.tbl_wr_ack  = 1'b0;
                    bus.tbl_rd_data = '0;
                    if (!AXI_RESETN) break;
                    if (!is_wr && k == stray_at) bus.tbl_wr_ack = 1'b1;
                    if (k == dly) begin
                        if (is_wr) begin
                            tbl_mem[a]     = d;
                            bus.tbl_wr_ack = 1'b1;
                        end else begin
                            bus.tbl_rd_ack  = 1'b1;
                            bus.tbl_rd_data = tbl_mem[a];
                        end
                    end
                end
            end
        end
    end

    // Reference model: one transaction record, timed by the stated latencies.
    bit            m_active, m_who, m_wr, m_err, m_last;
    logic [AW-1:0] m_addr, m_haddr;
    logic [EW-1:0] m_wdata, m_hwdata, m_rdata;
    int            m_issue, m_done;
    logic [31:0]   m_tocnt;
    int            h_ack_cnt = 0;
    int            e_ack_cnt = 0;
    int            wr_pulse_cnt = 0;
    string         ack_log = "";

    always @(negedge AXI_ACLK) begin
        bit xh, xe;
        if (bus.h_ack) begin h_ack_cnt++; ack_log = {ack_log, "H"}; end
        if (bus.e_ack) begin e_ack_cnt++; ack_log = {ack_log, "E"}; end
        if (bus.tbl_wr_req) wr_pulse_cnt++;

        if (!AXI_RESETN) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_haddr  = '0;
            m_hwdata = '0;
            m_tocnt  = '0;
            m_issue  = 0;
            m_done   = -1;
        end

        xh = m_active && (cyc == m_done) && !m_who;
        xe = m_active && (cyc == m_done) && m_who;
        chk("busy",        96'(busy),           96'(m_active && cyc >= m_issue));
        chk("tbl_rd_req",  96'(bus.tbl_rd_req), 96'(m_active && cyc == m_issue && !m_wr));
        chk("tbl_wr_req",  96'(bus.tbl_wr_req), 96'(m_active && cyc == m_issue && m_wr));
        chk("tbl_rd_addr", 96'(bus.tbl_rd_addr), 96'(m_haddr));
        chk("tbl_wr_addr", 96'(bus.tbl_wr_addr), 96'(m_haddr));
        chk("tbl_wr_data", bus.tbl_wr_data,     m_hwdata);
        chk("h_ack",       96'(bus.h_ack),      96'(xh));
        chk("h_err",       96'(bus.h_err),      96'(xh && m_err));
        chk("h_rdata",     bus.h_rdata,         xh ? m_rdata : '0);
        chk("e_ack",       96'(bus.e_ack),      96'(xe));
        chk("e_err",       96'(bus.e_err),      96'(xe && m_err));
        chk("e_rdata",     bus.e_rdata,         xe ? m_rdata : '0);
        chk("timeout_cnt", 96'(timeout_cnt),    96'(m_tocnt));

        if (AXI_RESETN) begin
            if (m_active && cyc == m_done) begin
                if (m_wr && !m_err) m_mem[m_addr] = m_wdata;
                m_active = 1'b0;  // requests in the ack cycle are not sampled
            end else if (m_active && m_done < 0 && cyc > m_issue) begin
                if (m_wr ? bus.tbl_wr_ack : bus.tbl_rd_ack) begin
                    m_done  = cyc + 1;
                    m_err   = 1'b0;
                    m_rdata = m_wr ? '0 : m_mem[m_addr];
                end else if (cyc - m_issue == TO) begin
                    m_done  = cyc + 1;
                    m_err   = 1'b1;
                    m_rdata = '0;
                    if (m_tocnt != 32'hFFFF_FFFF) m_tocnt = m_tocnt + 32'd1;
                end
            end else if (!m_active && (bus.h_req || bus.e_req)) begin
                m_who    = (bus.h_req && bus.e_req) ? !m_last : bus.e_req;
                m_last   = m_who;
                m_wr     = m_who ? bus.e_wr : bus.h_wr;
                m_addr   = m_who ? bus.e_addr : bus.h_addr;
                m_wdata  = m_who ? bus.e_wdata : bus.h_wdata;
                m_haddr  = m_addr;
                m_hwdata = m_wdata;
                m_issue  = cyc + 1;
                m_done   = -1;
                m_active = 1'b1;
            end
        end
    end

    // Called at posedge+1; raises req, waits (bounded) for ack, drops req the cycle after.
    task automatic do_txn(input bit eng, input bit wr, input logic [AW-1:0] addr,
                          input logic [EW-1:0] wd, output int req_cyc, output int ack_cyc,
                          output logic [EW-1:0] rd, output bit err);
        bit seen = 1'b0;
        if (eng) begin
            bus.e_wr = wr; bus.e_addr = addr; bus.e_wdata = wd; bus.e_req = 1'b1;
        end else begin
            bus.h_wr = wr; bus.h_addr = addr; bus.h_wdata = wd; bus.h_req = 1'b1;
        end
        req_cyc = cyc;
        ack_cyc = -1;
        rd      = '0;
        err     = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge AXI_ACLK);
            if (eng ? bus.e_ack : bus.h_ack) begin
                seen    = 1'b1;
                ack_cyc = cyc;
                rd      = eng ? bus.e_rdata : bus.h_rdata;
                err     = eng ? bus.e_err : bus.h_err;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_wait eng=%0d: got no ack, required one within 60 cycles", eng);
        end
        @(posedge AXI_ACLK);
        #1;
        if (eng) bus.e_req = 1'b0; else bus.h_req = 1'b0;
    endtask

    task automatic pulse_reset();
        AXI_RESETN = 1'b0;
        repeat (2) @(posedge AXI_ACLK);
        #1;
        AXI_RESETN = 1'b1;
        @(posedge AXI_ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        int            rc, ac, rc2, ac2, cnt0;
        logic [EW-1:0] rd, rd2;
        bit            er, er2;

        for (int i = 0; i < 32; i++) begin
            tbl_mem[i] = init_val(i);
            m_mem[i]   = init_val(i);
        end
        bus.h_req = 1'b0; bus.h_wr = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.e_req = 1'b0; bus.e_wr = 1'b0; bus.e_addr = '0; bus.e_wdata = '0;
        AXI_RESETN = 1'b0;
        repeat (3) @(posedge AXI_ACLK);
        #1;
        AXI_RESETN = 1'b1;
        @(posedge AXI_ACLK);
        #1;

        // Host write, table acks next cycle.
        cnt0 = wr_pulse_cnt;
        do_txn(1'b0, 1'b1, 5'd3, T1_DATA, rc, ac, rd, er);
        chk("t1_ack_latency", 96'(ac - rc), 96'd3);
        chk("t1_err", 96'(er), 96'd0);
        chk("t1_rdata", rd, 96'd0);
        chk("t1_wr_pulses", 96'(wr_pulse_cnt - cnt0), 96'd1);
        chk("t1_table", tbl_mem[3], 96'h0000_AABBCCDDEEFF_0A000001);

        // Simultaneous requests right after reset: host first, engine next.
        pulse_reset();
        fork
            do_txn(1'b0, 1'b0, 5'd5, '0, rc, ac, rd, er);
            do_txn(1'b1, 1'b1, 5'd7, T2_DATA, rc2, ac2, rd2, er2);
        join
        chk("t2_host_latency", 96'(ac - rc), 96'd3);
        chk("t2_host_rdata", rd, 96'hA5A50005_DEADBEEA_00001005);
        chk("t2_eng_after_host", 96'(ac2 - ac), 96'd4);
        chk("t2_eng_err", 96'(er2), 96'd0);
        chk("t2_table", tbl_mem[7], T2_DATA);

        // Continuous requests from both sides alternate grants.
        ack_log = "";
        fork
            begin
                int a1, a2; logic [EW-1:0] r1; bit e1;
                for (int i = 0; i < 3; i++)
                    do_txn(1'b0, 1'b1, 5'(10 + i), {64'h0, 32'(i)}, a1, a2, r1, e1);
            end
            begin
                int b1, b2; logic [EW-1:0] r2; bit e2;
                for (int i = 0; i < 3; i++)
                    do_txn(1'b1, 1'b0, 5'(i), '0, b1, b2, r2, e2);
            end
        join
        n_tests++;
        if (ack_log != "HEHEHE") begin
            n_fail++;
            $display("FAIL t3_grant_order: got %s, required HEHEHE", ack_log);
        end

        // Stray write ack during a read is ignored; read finishes on its own ack.
        stray_at = 1;
        rd_delay = 3;
        do_txn(1'b0, 1'b0, 5'd7, '0, rc, ac, rd, er);
        chk("t5_rdata", rd, 96'h1234_5678_9ABC_DEF0_0BAD_F00D);
        chk("t5_latency", 96'(ac - rc), 96'd5);
        chk("t5_err", 96'(er), 96'd0);
        stray_at = 0;

        // Table never acks a read: timeout.
        rd_delay = 0;
        do_txn(1'b1, 1'b0, 5'd4, '0, rc, ac, rd, er);
        chk("t4_err", 96'(er), 96'd1);
        chk("t4_rdata", rd, 96'd0);
        chk("t4_latency", 96'(ac - rc), 96'd18);
        chk("t4_timeout_cnt", 96'(timeout_cnt), 96'd1);
        @(negedge AXI_ACLK);
        chk("t4_busy_after", 96'(busy), 96'd0);

        // Reset during WAIT drops the transaction without an ack.
        @(posedge AXI_ACLK);
        #1;
        bus.h_wr = 1'b0; bus.h_addr = 5'd9; bus.h_req = 1'b1;
        repeat (4) @(posedge AXI_ACLK);
        #1;
        chk("t6_busy_in_wait", 96'(busy), 96'd1);
        cnt0 = h_ack_cnt;
        AXI_RESETN = 1'b0;
        bus.h_req  = 1'b0;
        #1;
        chk("t6_busy_async", 96'(busy), 96'd0);
        chk("t6_timeout_cleared", 96'(timeout_cnt), 96'd0);
        repeat (2) @(posedge AXI_ACLK);
        #1;
        AXI_RESETN = 1'b1;
        rd_delay   = 1;
        repeat (20) @(posedge AXI_ACLK);
        #1;
        chk("t6_no_ack", 96'(h_ack_cnt - cnt0), 96'd0);
        do_txn(1'b0, 1'b0, 5'd9, '0, rc, ac, rd, er);
        chk("t6_rdata", rd, 96'hA5A50009_DEADBEE6_00001009);
        chk("t6_latency", 96'(ac - rc), 96'd3);
        chk("t6_err", 96'(er), 96'd0);

        repeat (3) @(posedge AXI_ACLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
